// File: rtl/sram_responder_pkg.sv
// Shared definitions for the SRAM responder: bus widths, request direction
// encodings, UART-mapped addresses and the access state encoding.
package sram_responder_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 16;

    typedef logic [MEM_ADDR_W-1:0] mem_addr_bus_t;
    typedef logic [MEM_DATA_W-1:0] mem_bus_t;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;
    localparam logic ENABLE    = 1'b1;
    localparam logic DISABLE   = 1'b0;

    localparam mem_addr_bus_t UART_DATA_ADDR = 16'hBF00;
    localparam mem_addr_bus_t UART_STAT_ADDR = 16'hBF01;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_ACCESS = 3'd1,
        WR_SETUP  = 3'd2,
        WR_PULSE  = 3'd3,
        WR_HOLD   = 3'd4
    } state_t;

endpackage

// File: rtl/sram_responder_wait_counter.sv
// Loadable 3-bit down-counter that times the OE/WE strobe width.
// Stops at zero; zero flag tells the access FSM the strobe is complete.
module sram_wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    input  logic [2:0] load_value,
    output logic       zero
);

    logic [2:0] count;

    // Count register: load on strobe entry, otherwise count down to zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 3'd0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != 3'd0)) begin
            count <= count - 3'd1;
        end
    end

    assign zero = (count == 3'd0);

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder: turns pipeline memory requests into asynchronous
// SRAM read/write cycles with setup, strobe and hold phases.
// Optional macro UART_MAP_EN maps 0xBF00 (UART data) and 0xBF01 (UART
// status) away from the SRAM and adds the UART handshake ports.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int RAM_ADDR_W  = 18,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memEnable_i,
    input  logic                  memReadWrite_i,
    input  logic [ADDR_W-1:0]     memAddress_i,
    input  logic [DATA_W-1:0]     memDataWrite_i,
    output logic [DATA_W-1:0]     memDataRead_o,
    output logic                  ready_o,
    output logic                  done_o,
    output logic                  ram_ce_n_o,
    output logic                  ram_oe_n_o,
    output logic                  ram_we_n_o,
    output logic [RAM_ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0]     ram_data_o,
    output logic                  ram_data_oe_o,
    input  logic [DATA_W-1:0]     ram_data_i
`ifdef UART_MAP_EN
    ,
    output logic                  uart_rdn_o,
    output logic                  uart_wrn_o,
    input  logic                  uart_data_ready_i,
    input  logic                  uart_tbre_i,
    input  logic                  uart_tsre_i
`endif
);

    localparam logic [2:0] WAIT_LOAD = WAIT_STATES[2:0];

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                done_q;
    logic                cnt_load;
    logic                cnt_dec;
    logic                cnt_zero;
    logic                stat_hit;
    logic                uart_sel;
    logic [DATA_W-1:0]   status_word;

`ifdef UART_MAP_EN
    logic uart_rd_n;
    logic uart_wr_n;

    assign stat_hit    = (memAddress_i == UART_STAT_ADDR);
    assign status_word = {{(DATA_W-2){1'b0}}, uart_data_ready_i, uart_tbre_i & uart_tsre_i};

    // Remember whether the accepted access targets the UART data register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uart_sel <= 1'b0;
        end else if ((state == IDLE) && memEnable_i) begin
            uart_sel <= (memAddress_i == UART_DATA_ADDR);
        end
    end

    assign uart_rdn_o = uart_rd_n;
    assign uart_wrn_o = uart_wr_n;
`else
    assign stat_hit    = 1'b0;
    assign status_word = '0;
    assign uart_sel    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; an X direction falls through to the read branch
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (memEnable_i) begin
                    if (stat_hit) begin
                        state_next = IDLE;
                    end else if (memReadWrite_i == MEM_WRITE) begin
                        state_next = WR_SETUP;
                    end else begin
                        state_next = RD_ACCESS;
                    end
                end
            end
            RD_ACCESS: if (cnt_zero) state_next = IDLE;
            WR_SETUP:  state_next = WR_PULSE;
            WR_PULSE:  if (cnt_zero) state_next = WR_HOLD;
            WR_HOLD:   state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    assign cnt_load = ((state_next == RD_ACCESS) && (state != RD_ACCESS)) ||
                      ((state_next == WR_PULSE) && (state != WR_PULSE));
    assign cnt_dec  = (state == RD_ACCESS) || (state == WR_PULSE);

    sram_wait_counter u_wait (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .dec        (cnt_dec),
        .load_value (WAIT_LOAD),
        .zero       (cnt_zero)
    );

    // Strobe decode from the registered state so pins change only after an edge
    always_comb begin
        ram_ce_n_o    = 1'b1;
        ram_oe_n_o    = 1'b1;
        ram_we_n_o    = 1'b1;
        ram_data_oe_o = 1'b0;
`ifdef UART_MAP_EN
        uart_rd_n     = 1'b1;
        uart_wr_n     = 1'b1;
`endif
        case (state)
            RD_ACCESS: begin
                if (uart_sel) begin
`ifdef UART_MAP_EN
                    uart_rd_n = 1'b0;
`endif
                end else begin
                    ram_ce_n_o = 1'b0;
                    ram_oe_n_o = 1'b0;
                end
            end
            WR_SETUP, WR_HOLD: begin
                ram_ce_n_o    = uart_sel;
                ram_data_oe_o = 1'b1;
            end
            WR_PULSE: begin
                ram_ce_n_o    = uart_sel;
                ram_data_oe_o = 1'b1;
                if (uart_sel) begin
`ifdef UART_MAP_EN
                    uart_wr_n = 1'b0;
`endif
                end else begin
                    ram_we_n_o = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Request capture, read-data latch and completion pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= DISABLE;
        end else begin
            done_q <= DISABLE;
            if ((state == IDLE) && memEnable_i) begin
                addr_q  <= memAddress_i;
                wdata_q <= memDataWrite_i;
                if (stat_hit) begin
                    done_q <= ENABLE;
                    if (memReadWrite_i == MEM_WRITE) begin
                        rdata_q <= rdata_q;
                    end else begin
                        rdata_q <= status_word;
                    end
                end
            end
            if ((state == RD_ACCESS) && cnt_zero) begin
                rdata_q <= ram_data_i;
                done_q  <= ENABLE;
            end
            if (state == WR_HOLD) begin
                done_q <= ENABLE;
            end
        end
    end

    assign ready_o       = (state == IDLE);
    assign done_o        = done_q;
    assign memDataRead_o = rdata_q;
    assign ram_addr_o    = {{(RAM_ADDR_W-ADDR_W){1'b0}}, addr_q};
    assign ram_data_o    = wdata_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: one instance with the default single
// wait state and one with zero wait states, each behind a small SRAM model.
module tb_sram_responder;
    import sram_responder_pkg::*;

    logic clk = 1'b0;
    logic rst;

    logic        mem_enable, mem_rw;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        ready, done, ce_n, oe_n, we_n, data_oe;
    logic [17:0] ram_addr;
    logic [15:0] ram_wdata, ram_rdata;

    logic        mem_enable_z, mem_rw_z;
    logic [15:0] mem_addr_z, mem_wdata_z, mem_rdata_z;
    logic        ready_z, done_z, ce_n_z, oe_n_z, we_n_z, data_oe_z;
    logic [17:0] ram_addr_z;
    logic [15:0] ram_wdata_z, ram_rdata_z;

`ifdef UART_MAP_EN
    logic uart_rdn, uart_wrn, uart_rdn_z, uart_wrn_z;
    logic uart_dr = 1'b1;
    logic uart_tbre = 1'b1;
    logic uart_tsre = 1'b1;
    logic uart_zero = 1'b0;
`endif

    logic [15:0] mem1 [int];
    logic [15:0] mem0 [int];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_responder #(.WAIT_STATES(1)) dut (
        .clk(clk), .rst(rst),
        .memEnable_i(mem_enable), .memReadWrite_i(mem_rw),
        .memAddress_i(mem_addr), .memDataWrite_i(mem_wdata),
        .memDataRead_o(mem_rdata), .ready_o(ready), .done_o(done),
        .ram_ce_n_o(ce_n), .ram_oe_n_o(oe_n), .ram_we_n_o(we_n),
        .ram_addr_o(ram_addr), .ram_data_o(ram_wdata),
        .ram_data_oe_o(data_oe), .ram_data_i(ram_rdata)
`ifdef UART_MAP_EN
        , .uart_rdn_o(uart_rdn), .uart_wrn_o(uart_wrn),
        .uart_data_ready_i(uart_dr), .uart_tbre_i(uart_tbre), .uart_tsre_i(uart_tsre)
`endif
    );

    sram_responder #(.WAIT_STATES(0)) dut_z (
        .clk(clk), .rst(rst),
        .memEnable_i(mem_enable_z), .memReadWrite_i(mem_rw_z),
        .memAddress_i(mem_addr_z), .memDataWrite_i(mem_wdata_z),
        .memDataRead_o(mem_rdata_z), .ready_o(ready_z), .done_o(done_z),
        .ram_ce_n_o(ce_n_z), .ram_oe_n_o(oe_n_z), .ram_we_n_o(we_n_z),
        .ram_addr_o(ram_addr_z), .ram_data_o(ram_wdata_z),
        .ram_data_oe_o(data_oe_z), .ram_data_i(ram_rdata_z)
`ifdef UART_MAP_EN
        , .uart_rdn_o(uart_rdn_z), .uart_wrn_o(uart_wrn_z),
        .uart_data_ready_i(uart_zero), .uart_tbre_i(uart_zero), .uart_tsre_i(uart_zero)
`endif
    );

    // SRAM model for the one-wait-state instance, 0x0040 preloaded with 0x1234
    always @(negedge clk) begin
        if (rst === 1'b0 && !mem1.exists(32'h40)) mem1[32'h40] = 16'h1234;
        if (!ce_n && !we_n && data_oe) mem1[int'(ram_addr)] = ram_wdata;
        if (!ce_n && !oe_n && mem1.exists(int'(ram_addr))) ram_rdata = mem1[int'(ram_addr)];
        else ram_rdata = 16'hDEAD;
    end

    // SRAM model for the zero-wait-state instance
    always @(negedge clk) begin
        if (!ce_n_z && !we_n_z && data_oe_z) mem0[int'(ram_addr_z)] = ram_wdata_z;
        if (!ce_n_z && !oe_n_z && mem0.exists(int'(ram_addr_z))) ram_rdata_z = mem0[int'(ram_addr_z)];
        else ram_rdata_z = 16'hDEAD;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // OE and WE must never be low together on either instance
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            checkOutput("oe_we_exclusive", {31'b0, ~oe_n & ~we_n}, 32'd0);
            checkOutput("oe_we_exclusive_z", {31'b0, ~oe_n_z & ~we_n_z}, 32'd0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic rw, input logic [15:0] a, input logic [15:0] d);
        mem_enable = en;
        mem_rw     = rw;
        mem_addr   = a;
        mem_wdata  = d;
    endtask

    task automatic writeZ(input logic [15:0] a, input logic [15:0] d);
        mem_enable_z = 1'b1; mem_rw_z = MEM_WRITE; mem_addr_z = a; mem_wdata_z = d;
        tick;
        checkOutput("z_wr_setup_we", {31'b0, we_n_z}, 32'd1);
        checkOutput("z_wr_setup_doe", {31'b0, data_oe_z}, 32'd1);
        checkOutput("z_wr_setup_addr", {14'b0, ram_addr_z}, {16'b0, a});
        mem_enable_z = 1'b0;
        tick;
        checkOutput("z_wr_pulse_we", {31'b0, we_n_z}, 32'd0);
        checkOutput("z_wr_pulse_data", {16'b0, ram_wdata_z}, {16'b0, d});
        tick;
        checkOutput("z_wr_hold_we", {31'b0, we_n_z}, 32'd1);
        checkOutput("z_wr_hold_ready", {31'b0, ready_z}, 32'd0);
        tick;
        checkOutput("z_wr_done", {31'b0, done_z}, 32'd1);
        checkOutput("z_wr_done_doe", {31'b0, data_oe_z}, 32'd0);
    endtask

    task automatic readZ(input logic [15:0] a, input logic [15:0] expd);
        mem_enable_z = 1'b1; mem_rw_z = MEM_READ; mem_addr_z = a; mem_wdata_z = 16'h0;
        tick;
        checkOutput("z_rd_oe", {31'b0, oe_n_z}, 32'd0);
        checkOutput("z_rd_addr", {14'b0, ram_addr_z}, {16'b0, a});
        mem_enable_z = 1'b0;
        tick;
        checkOutput("z_rd_done", {31'b0, done_z}, 32'd1);
        checkOutput("z_rd_data", {16'b0, mem_rdata_z}, {16'b0, expd});
        checkOutput("z_rd_ready", {31'b0, ready_z}, 32'd1);
    endtask

    // Directed sequence
    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, MEM_READ, 16'h0, 16'h0);
        mem_enable_z = 1'b0; mem_rw_z = MEM_READ; mem_addr_z = 16'h0; mem_wdata_z = 16'h0;
        #12;
        checkOutput("rst_ready", {31'b0, ready}, 32'd1);
        checkOutput("rst_strobes", {29'b0, ce_n, oe_n, we_n}, 32'd7);
        checkOutput("rst_doe", {31'b0, data_oe}, 32'd0);
        checkOutput("rst_addr", {14'b0, ram_addr}, 32'd0);
        checkOutput("rst_rdata", {16'b0, mem_rdata}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        @(negedge clk) rst = 1'b1;
        tick;

        // Read 0x0040 while the requester wiggles enable/address
        applyStimulus(1'b1, MEM_READ, 16'h0040, 16'h0);
        tick;
        checkOutput("rd1_ce_oe_we", {29'b0, ce_n, oe_n, we_n}, 32'd1);
        checkOutput("rd1_doe", {31'b0, data_oe}, 32'd0);
        checkOutput("rd1_addr", {14'b0, ram_addr}, 32'h00040);
        checkOutput("rd1_ready", {31'b0, ready}, 32'd0);
        applyStimulus(1'b0, MEM_WRITE, 16'h2222, 16'h1111);
        tick;
        checkOutput("rd2_oe", {31'b0, oe_n}, 32'd0);
        checkOutput("rd2_done", {31'b0, done}, 32'd0);
        applyStimulus(1'b1, MEM_WRITE, 16'h7FFF, 16'hBEEF);
        tick;
        checkOutput("rd3_done", {31'b0, done}, 32'd1);
        checkOutput("rd3_data", {16'b0, mem_rdata}, 32'h1234);
        checkOutput("rd3_ready", {31'b0, ready}, 32'd1);
        checkOutput("rd3_ce_oe", {30'b0, ce_n, oe_n}, 32'd3);
        checkOutput("rd3_addr_held", {14'b0, ram_addr}, 32'h00040);

        // Write 0xBEEF to 0x7FFF accepted after one idle cycle
        tick;
        checkOutput("wr_setup_strobes", {29'b0, ce_n, oe_n, we_n}, 32'd3);
        checkOutput("wr_setup_doe", {31'b0, data_oe}, 32'd1);
        checkOutput("wr_setup_addr", {14'b0, ram_addr}, 32'h07FFF);
        checkOutput("wr_setup_data", {16'b0, ram_wdata}, 32'hBEEF);
        checkOutput("wr_setup_ready", {31'b0, ready}, 32'd0);
        applyStimulus(1'b0, MEM_READ, 16'h3333, 16'h4444);
        tick;
        checkOutput("wr_pulse1_we", {31'b0, we_n}, 32'd0);
        checkOutput("wr_pulse1_data", {16'b0, ram_wdata}, 32'hBEEF);
        tick;
        checkOutput("wr_pulse2_we", {31'b0, we_n}, 32'd0);
        checkOutput("wr_pulse2_addr", {14'b0, ram_addr}, 32'h07FFF);
        tick;
        checkOutput("wr_hold_we", {31'b0, we_n}, 32'd1);
        checkOutput("wr_hold_ce_doe", {30'b0, ce_n, data_oe}, 32'd1);
        checkOutput("wr_hold_done", {31'b0, done}, 32'd0);
        applyStimulus(1'b1, MEM_READ, 16'h7FFF, 16'h0);
        tick;
        checkOutput("wr_done", {31'b0, done}, 32'd1);
        checkOutput("wr_done_ce_not_accepted", {31'b0, ce_n}, 32'd1);
        checkOutput("wr_done_doe", {31'b0, data_oe}, 32'd0);
        checkOutput("wr_done_ready", {31'b0, ready}, 32'd1);

        // Read back 0x7FFF
        tick;
        checkOutput("rb_oe", {31'b0, oe_n}, 32'd0);
        checkOutput("rb_addr", {14'b0, ram_addr}, 32'h07FFF);
        applyStimulus(1'b0, MEM_READ, 16'h0, 16'h0);
        tick;
        tick;
        checkOutput("rb_done", {31'b0, done}, 32'd1);
        checkOutput("rb_data", {16'b0, mem_rdata}, 32'hBEEF);

        // Unknown direction behaves as a read
        applyStimulus(1'b1, 1'bx, 16'h0040, 16'hFFFF);
        tick;
        checkOutput("xdir_oe_we", {30'b0, oe_n, we_n}, 32'd1);
        checkOutput("xdir_doe", {31'b0, data_oe}, 32'd0);
        applyStimulus(1'b0, MEM_READ, 16'h0, 16'h0);
        tick;
        tick;
        checkOutput("xdir_data", {16'b0, mem_rdata}, 32'h1234);

        // Asynchronous reset in the middle of the write strobe
        applyStimulus(1'b1, MEM_WRITE, 16'h0001, 16'h5555);
        tick;
        applyStimulus(1'b0, MEM_READ, 16'h0, 16'h0);
        tick;
        checkOutput("rstw_pre_we", {31'b0, we_n}, 32'd0);
        #2 rst = 1'b0;
        #1;
        checkOutput("rstw_ce_we", {30'b0, ce_n, we_n}, 32'd3);
        checkOutput("rstw_doe", {31'b0, data_oe}, 32'd0);
        checkOutput("rstw_ready", {31'b0, ready}, 32'd1);
        checkOutput("rstw_addr", {14'b0, ram_addr}, 32'd0);
        checkOutput("rstw_rdata", {16'b0, mem_rdata}, 32'd0);
        @(negedge clk) rst = 1'b1;
        tick;

        // Zero-wait-state sweep on the second instance
        writeZ(16'h0000, 16'hA5A5);
        readZ(16'h0000, 16'hA5A5);
        writeZ(16'hFFFF, 16'h5A5A);
        readZ(16'hFFFF, 16'h5A5A);
        readZ(16'h0000, 16'hA5A5);

`ifdef UART_MAP_EN
        // UART status read completes on the accept edge without touching SRAM
        applyStimulus(1'b1, MEM_READ, 16'hBF01, 16'h0);
        tick;
        checkOutput("uart_stat_done", {31'b0, done}, 32'd1);
        checkOutput("uart_stat_data", {16'b0, mem_rdata}, 32'h0003);
        checkOutput("uart_stat_ce", {31'b0, ce_n}, 32'd1);
        applyStimulus(1'b0, MEM_READ, 16'h0, 16'h0);
        tick;
        // UART data write strobes uart_wrn instead of we_n
        applyStimulus(1'b1, MEM_WRITE, 16'hBF00, 16'h0041);
        tick;
        checkOutput("uart_wr_ce", {31'b0, ce_n}, 32'd1);
        checkOutput("uart_wr_data", {16'b0, ram_wdata}, 32'h0041);
        applyStimulus(1'b0, MEM_READ, 16'h0, 16'h0);
        tick;
        checkOutput("uart_wr_wrn", {31'b0, uart_wrn}, 32'd0);
        checkOutput("uart_wr_we", {31'b0, we_n}, 32'd1);
        tick;
        tick;
        checkOutput("uart_wr_done", {31'b0, done}, 32'd1);
`endif

        tick;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the pipeline's memory request interface (enable, read/write, address, write data, read data).
- Converts each accepted request into multi-cycle asynchronous-SRAM timing on the board RAM pins: CE/OE/WE strobes, 18-bit address, split 16-bit data bus with output-enable. The top level builds the tristate from the split bus.
- Sits between the instruction/data memory arbiter and the SRAM pads.
- Returns read data and a completion pulse.

Parameters:
- ADDR_W, 16, request address width (`MemAddrBus`).
- DATA_W, 16, data width (`MemBus`).
- RAM_ADDR_W, 18, SRAM pin address width.
- WAIT_STATES, 1, extra cycles the OE/WE strobe is held low; legal range 0..7.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- memEnable_i  in  1  request valid.
- memReadWrite_i  in  1  `MemRead`(0) / `MemWrite`(1).
- memAddress_i  in  ADDR_W  request word address.
- memDataWrite_i  in  DATA_W  write data.
- memDataRead_o  out  DATA_W  last read result, held until the next read completes.
- ready_o  out  1  high when idle and able to accept a request.
- done_o  out  1  one-cycle pulse when a request completes.
- ram_ce_n_o  out  1  SRAM chip enable, active-low.
- ram_oe_n_o  out  1  SRAM output enable, active-low.
- ram_we_n_o  out  1  SRAM write enable, active-low.
- ram_addr_o  out  RAM_ADDR_W  {zero-extend, captured address}.
- ram_data_o  out  DATA_W  data toward the pads.
- ram_data_oe_o  out  1  1 = drive pads with ram_data_o.
- ram_data_i  in  DATA_W  data from the pads.
- UART ports, present only with UART_MAP_EN (see Optional Feature).

Behaviour:
- Reset: asynchronous, rst=0 takes effect immediately, mid-operation included.
  - state=IDLE; ce_n=oe_n=we_n=1; data_oe=0; ram_addr=0; ram_data_o=0.
  - memDataRead_o=0; done_o=0; ready_o=1.
  - An interrupted write leaves SRAM contents undefined at that address.
- Accept: on a rising edge with state=IDLE and memEnable_i=1, register the address, write data and direction.
  - memEnable_i while busy is ignored; the requester holds the request until ready_o=1.
  - ready_o = (state==IDLE), registered.
- States: IDLE, RD_ACCESS, WR_SETUP, WR_PULSE, WR_HOLD. A 3-bit wait counter is loaded with WAIT_STATES on entry to RD_ACCESS or WR_PULSE.
- Read path:
  - IDLE->RD_ACCESS: ce_n=0, oe_n=0, we_n=1, data_oe=0, address driven.
  - RD_ACCESS lasts WAIT_STATES+1 cycles.
  - On its final edge: memDataRead_o<=ram_data_i, done_o=1 for the following cycle, state->IDLE, ce_n=oe_n=1.
  - Request-edge to data-valid latency = WAIT_STATES+2 edges (3 with the default).
- Write path:
  - WR_SETUP, 1 cycle: ce_n=0, we_n=1, oe_n=1, data_oe=1, data and address stable.
  - WR_PULSE, WAIT_STATES+1 cycles: we_n=0.
  - WR_HOLD, 1 cycle: we_n=1, data_oe=1, address held. Exit to IDLE with done_o=1 and ce_n=1.
  - Total WAIT_STATES+3 cycles busy.
- Invariants:
  - oe_n and we_n are never both 0.
  - data_oe=1 only in the WR_* states.
  - Address and data are constant for the whole access, including setup/hold.
- Back-to-back: a request present on the same edge that returns to IDLE is not accepted. It is accepted on the next edge, giving one idle cycle between strobes.
- Unknown direction (X) is treated as read.

Optional Feature:
- Macro: UART_MAP_EN.
- Defined:
  - Address 16'hBF00 and 16'hBF01 bypass the SRAM. Extra ports: uart_rdn_o, uart_wrn_o (out, active-low), uart_data_ready_i, uart_tbre_i, uart_tsre_i (in).
  - Read of BF00: uart_rdn_o low for the RD_ACCESS duration, data captured from ram_data_i.
  - Write of BF00: uart_wrn_o low in place of we_n. ce_n stays 1 for both BF00 accesses.
  - Read of BF01 completes in 1 cycle: memDataRead_o = {14'b0, uart_data_ready_i, uart_tbre_i & uart_tsre_i}. Writes to BF01 are ignored but still pulse done_o.
- Undefined: all addresses go to SRAM and the UART ports are absent.

Decomposition:
- Shared package/defines:
  - state encodings;
  - `MemRead`/`MemWrite`;
  - UART addresses 16'hBF00/16'hBF01;
  - `MemAddrBus`, `MemBus`, `Enable`/`Disable`.
- Natural sub-module: sram_wait_counter (loadable down-counter with zero flag), shared by the read and write paths.

Test Plan:
- Reset mid-write: assert rst=0 during WR_PULSE -> same-cycle ce_n=we_n=1, data_oe=0, ready_o=1.
- Read, WAIT_STATES=1: SRAM model holds 0x1234 at 0x0040; request read addr 0x0040 -> ram_addr=0x00040, oe_n low 2 cycles, memDataRead_o=0x1234 and done_o at edge 3, ready_o back high.
- Write then read: write 0xBEEF to 0x7FFF, then read 0x7FFF -> we_n low exactly 2 cycles, data_oe spans setup..hold, read returns 0xBEEF. A checker asserts oe_n&we_n never both 0.
- Busy ignore: change memAddress_i and toggle memEnable_i every cycle during a read -> captured address unchanged. The next request is accepted only after one idle cycle.
- WAIT_STATES=0 sweep: alternating read/write to 0x0000/0xFFFF -> read latency 2 edges, write busy 3 cycles, data correct.
- UART_MAP_EN, status read: uart_data_ready_i=1, tbre=tsre=1, read 0xBF01 -> memDataRead_o=0x0003 in 1 cycle, ce_n stays 1.
- UART_MAP_EN, data write: write 0x0041 to 0xBF00 -> uart_wrn_o pulses low, we_n stays 1.
